// File: rtl/mem_stage_lsu.sv
// Memory stage of the RV64IMFD pipeline: issues loads/stores over a variable-latency
// data port, aligns byte lanes, extracts/extends load data and raises precise traps.
module mem_stage_lsu #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ADDR_W      = 48,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                valid_ex,
  output logic                ready_ex,
  input  logic                flush_mem,
  input  logic [4:0]          mem_op_ex,
  input  logic [ADDR_W-1:0]   mem_addr_ex,
  input  logic [XLEN-1:0]     op_ex,
  input  logic [4:0]          rd_ex,
  input  logic                we_rd_ex,
  input  logic                reg_type_ex,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                valid_mem,
  output logic [XLEN-1:0]     op_mem,
  output logic [4:0]          rd_mem,
  output logic                we_rd_mem,
  output logic                reg_type_mem,
  output logic                trap_mem,
  output logic [3:0]          trap_cause_mem
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  typedef struct packed {
    logic              store;
    logic              uns;
    logic [1:0]        size;
    logic [OFF_W-1:0]  off;
    logic              flt;
    logic [4:0]        rd;
    logic              we;
    logic [XLEN-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [XLEN-1:0]   wdata;
  } req_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] op;
    logic [4:0]      rd;
    logic            we;
    logic            rt;
    logic            trap;
    logic [3:0]      cause;
  } res_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flushed_q, flushed_d;
  req_t             req_q, req_d;
  res_t             res_q, res_d;

  // Request decode from the EX inputs
  logic [OFF_W-1:0] off_ex;
  logic [OFF_W-1:0] size_mask_ex;
  logic [BE_W-1:0]  be_base_ex;
  logic             misaligned_ex;

  always_comb begin
    off_ex = mem_addr_ex[OFF_W-1:0];
    unique case (mem_op_ex[1:0])
      2'd0:    size_mask_ex = '0;
      2'd1:    size_mask_ex = OFF_W'(1);
      2'd2:    size_mask_ex = OFF_W'(3);
      default: size_mask_ex = OFF_W'(7);
    endcase
    misaligned_ex = |(off_ex & size_mask_ex);
    for (int i = 0; i < BE_W; i++) begin
      be_base_ex[i] = (i < (1 << int'(mem_op_ex[1:0])));
    end
  end

  // Load data extraction from the latched request
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_mask;
  logic [XLEN-1:0] nan_box;
  logic            ld_sign;
  logic [XLEN-1:0] ld_val;

  always_comb begin
    ld_shift = mem_rdata >> {req_q.off, 3'b000};
    for (int i = 0; i < XLEN; i++) begin
      ld_mask[i] = (i < (8 << int'(req_q.size)));
      nan_box[i] = (i >= 32);
    end
    unique case (req_q.size)
      2'd0:    ld_sign = ld_shift[7];
      2'd1:    ld_sign = ld_shift[15];
      2'd2:    ld_sign = ld_shift[31];
      default: ld_sign = ld_shift[XLEN-1];
    endcase
    ld_val = ld_shift & ld_mask;
    if (!req_q.uns && ld_sign) ld_val = ld_val | ~ld_mask;
    // Single-precision values in a 64-bit register are NaN-boxed
    if (req_q.flt && (req_q.size == 2'd2)) ld_val = ld_val | nan_box;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flushed_d = flushed_q;
    req_d     = req_q;
    res_d     = '0;

    unique case (state_q)
      StIdle: begin
        if (valid_ex && !flush_mem) begin
          res_d.rd = rd_ex;
          res_d.rt = reg_type_ex;
          res_d.op = op_ex;
          if (!mem_op_ex[4]) begin
            res_d.valid = 1'b1;
            res_d.we    = we_rd_ex;
          end else if ((XLEN == 32) && (mem_op_ex[1:0] == 2'd3)) begin
            res_d.valid = 1'b1;
            res_d.trap  = 1'b1;
            res_d.cause = 4'd2;
          end else if (misaligned_ex) begin
            res_d.valid = 1'b1;
            res_d.trap  = 1'b1;
            res_d.cause = mem_op_ex[3] ? 4'd6 : 4'd4;
          end else begin
            req_d.store = mem_op_ex[3];
            req_d.uns   = mem_op_ex[2];
            req_d.size  = mem_op_ex[1:0];
            req_d.off   = off_ex;
            req_d.flt   = reg_type_ex;
            req_d.rd    = rd_ex;
            req_d.we    = we_rd_ex;
            req_d.op    = op_ex;
            req_d.addr  = {mem_addr_ex[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            req_d.be    = be_base_ex << off_ex;
            req_d.wdata = op_ex << {off_ex, 3'b000};
            cnt_d       = '0;
            flushed_d   = 1'b0;
            state_d     = StBusy;
          end
        end
      end
      StBusy: begin
        // A flush cannot abandon the bus cycle, only its result
        flushed_d = flushed_q | flush_mem;
        res_d.rd  = req_q.rd;
        res_d.rt  = req_q.flt;
        res_d.op  = req_q.op;
        if (mem_ack) begin
          state_d     = StIdle;
          res_d.valid = !flushed_d;
          if (!req_q.store) begin
            res_d.op = ld_val;
            res_d.we = req_q.we;
          end
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CntLast)) begin
          state_d     = StIdle;
          res_d.valid = !flushed_d;
          res_d.trap  = !flushed_d;
          res_d.cause = req_q.store ? 4'd7 : 4'd5;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!res_d.valid) res_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      req_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
      req_q     <= req_d;
      res_q     <= res_d;
    end
  end

  logic busy;
  assign busy = (state_q == StBusy);

  assign ready_ex       = !busy;
  assign mem_req        = busy;
  assign mem_we         = busy & req_q.store;
  assign mem_addr       = busy ? req_q.addr : '0;
  assign mem_be         = busy ? req_q.be : '0;
  assign mem_wdata      = busy ? req_q.wdata : '0;
  assign valid_mem      = res_q.valid & ~flush_mem;
  assign trap_mem       = res_q.trap & ~flush_mem;
  assign op_mem         = res_q.op;
  assign rd_mem         = res_q.rd;
  assign we_rd_mem      = res_q.we;
  assign reg_type_mem   = res_q.rt;
  assign trap_cause_mem = res_q.cause;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised memory stage (stage 4) of the RV64IMFD pipeline, sitting between execute and writeback.
- Accepts one EX-stage operation at a time over a valid/ready handshake and issues loads/stores to a data-memory port with a variable-latency acknowledge.
- Aligns store data into byte lanes and extracts, sign/zero-extends and NaN-boxes load data.
- Raises precise traps for misalignment and bus timeout.
- Non-memory operations pass through with one cycle of latency.

Parameters:
XLEN, 64, datapath width; 32 or 64 only.
ADDR_W, 48, address width.
TIMEOUT_CYC, 255, cycles mem_req may stay unacknowledged before access fault; 0 disables timeout.

Ports:
clk  input  1  clock, rising edge
n_reset  input  1  asynchronous active-low reset
valid_ex  input  1  EX presents an operation
ready_ex  output  1  stage can accept (handshake completes when valid_ex && ready_ex)
flush_mem  input  1  discard current/incoming op (pipeline redirect)
mem_op_ex  input  5  [4] memory access, [3] store(1)/load(0), [2] unsigned, [1:0] size B/H/W/D
mem_addr_ex  input  ADDR_W  effective address
op_ex  input  XLEN  ALU result or store data
rd_ex  input  5  destination register
we_rd_ex  input  1  destination write enable
reg_type_ex  input  1  0 integer, 1 float register file
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = write
mem_addr  output  ADDR_W  address aligned down to XLEN/8 bytes
mem_be  output  XLEN/8  byte enables
mem_wdata  output  XLEN  lane-shifted store data
mem_ack  input  1  request complete; mem_rdata valid for loads
mem_rdata  input  XLEN  read data
valid_mem  output  1  result valid to writeback (one-cycle pulse per op)
op_mem  output  XLEN  load result or passed-through op_ex
rd_mem  output  5  destination register
we_rd_mem  output  1  register write enable
reg_type_mem  output  1  register file select
trap_mem  output  1  exception on this op
trap_cause_mem  output  4  mcause code, valid when trap_mem

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. Reset mid-request drops mem_req immediately; no result is produced.
- FSM states:
  - IDLE: ready_ex=1. On accept, decode the op:
    - Non-memory: registered to outputs; valid_mem=1 next cycle; stay in IDLE.
    - Misaligned (offset bits for the size nonzero; B never misaligned): valid_mem next cycle, trap_mem=1, cause 4 for load / 6 for store, we_rd_mem=0; no mem_req.
    - Size D with XLEN=32: trap, cause 2.
    - Otherwise: latch the op, go to BUSY.
  - BUSY: ready_ex=0, mem_req=1 with stable mem_we/addr/be/wdata.
    - mem_ack: capture result, pulse valid_mem the next cycle, return to IDLE. The earliest ack is the first BUSY cycle, giving 2-cycle latency accept→valid_mem.
    - No ack: counter increments. When it reaches TIMEOUT_CYC, deassert mem_req, trap cause 5 (load) / 7 (store), valid_mem next cycle, return to IDLE.
- mem_ack while not in BUSY: ignored.
- Byte lanes, with off = addr[log2(XLEN/8)-1:0] and n = 1<<size:
  - mem_be = ((1<<n)-1) << off
  - mem_wdata = op_ex << 8*off
  - mem_addr has the offset bits zeroed
- Load extract: mem_rdata >> 8*off, truncated to n bytes, then:
  - Sign-extended if [2]=0, zero-extended if [2]=1.
  - Float load of size W with XLEN=64: upper 32 bits forced to all ones (NaN-box), regardless of [2].
- Writeback fields:
  - Stores: we_rd_mem=0, op_mem=op_ex.
  - Loads: we_rd_mem=we_rd_ex.
  - Any trap: we_rd_mem=0.
- flush_mem:
  - In IDLE: blocks acceptance that cycle; no valid_mem.
  - In BUSY: the request continues to ack or timeout (bus is not abandonable), but valid_mem and trap_mem stay 0 for that op.
  - Asserted in the result cycle: suppresses valid_mem.
- valid_mem is a single-cycle pulse; writeback cannot stall this stage.

Test Plan:
1. Non-memory pass-through: accept op_ex=0x1234, rd=7, we=1 → valid_mem next cycle, op_mem=0x1234, rd_mem=7, we_rd_mem=1, mem_req never asserted.
2. LB at addr 0x...3, mem_rdata=0x00000000_80000000 with 3-cycle ack delay → mem_be=0x08, valid_mem one cycle after ack, op_mem=0xFFFFFFFF_FFFFFF80. Repeat as LBU → 0x80.
3. SH at addr 0x6 with op_ex=0xABCD → mem_we=1, mem_be=0xC0, mem_wdata=0xABCD0000_00000000, we_rd_mem=0; ready_ex low until ack.
4. LW at addr 0x2 → no mem_req, trap_mem=1, cause 4. SD at addr 0x4 → cause 6.
5. Timeout: TIMEOUT_CYC=4, LD with no ack → mem_req low after 4 BUSY cycles, trap cause 5. FLW at 0x4 with ack, mem_rdata=0x3F800000_00000000 → op_mem=0xFFFFFFFF_3F800000, reg_type_mem=1.
6. Flush and reset:
   - flush_mem pulse during BUSY → ack still consumed, no valid_mem.
   - n_reset low mid-BUSY → all outputs 0 asynchronously; a later stray ack is ignored.
